// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: SBOX_LANES bytes per cycle through shared forward/inverse S-boxes,
// with a registered result handed to ShiftRows over valid/ready.
module sub_bytes_iter #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);
    localparam int NGRP  = 16 / SBOX_LANES;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("SBOX_LANES must be one of 1, 2, 4, 8, 16");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^240 * x^12 * x^2; maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, t;
        x2  = gf_mul(x, x);
        x3  = gf_mul(x2, x);
        t   = gf_mul(x3, x3);
        x12 = gf_mul(t, t);
        t   = gf_mul(x12, x3);
        for (int i = 0; i < 4; i++) t = gf_mul(t, t);
        return gf_mul(gf_mul(t, x12), x2);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] q;
        q = gf_inv(x);
        return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^
               {q[3:0], q[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [0:127]       work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inv_q, inv_d;

    logic [7:0]   work_b   [16];
    logic [3:0]   lane_idx [SBOX_LANES];
    logic [7:0]   lane_in  [SBOX_LANES];
    logic [7:0]   lane_out [SBOX_LANES];
    logic [0:127] run_data;

    // Each lane owns one forward and one inverse S-box; the lane reads byte cnt*LANES+l.
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(cnt_q) * SBOX_LANES + l);
        assign lane_in[l]  = work_b[lane_idx[l]];
        assign lane_out[l] = inv_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
    end

    // Only the bytes of the active group are replaced; the rest pass through.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign work_b[i] = work_q[8*i +: 8];
        assign run_data[8*i +: 8] = (cnt_q == CNT_W'(i / SBOX_LANES))
                                    ? lane_out[i % SBOX_LANES] : work_b[i];
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and data stable until that edge, and ready never depends on valid.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    work_d  = in_data;
                    inv_d   = inv;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                work_d = run_data;
                if (cnt_q == CNT_W'(NGRP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = !rst && (state_q == S_IDLE);
    assign out_valid = !rst && (state_q == S_DONE);
    assign busy      = !rst && (state_q != S_IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: vector table plus backpressure, abort and lane-count sequences,
// checked against an S-box model built from log/antilog tables.
module tb_sub_bytes_iter;
    localparam int LANES = 4;
    localparam int NGRP  = 16 / LANES;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, inv, out_valid, out_ready, busy;
    logic [0:127] in_data, out_data;

    sub_bytes_iter #(.SBOX_LANES(LANES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inv(inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    logic         sw_in_valid [4];
    logic         sw_in_ready [4];
    logic         sw_out_valid[4];
    logic         sw_out_ready[4];
    logic         sw_busy     [4];
    logic [0:127] sw_out_data [4];
    logic [0:127] sw_in_data;
    logic         sw_inv;

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sub_bytes_iter #(.SBOX_LANES(L)) u_sw (
            .clk(clk), .rst(rst), .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
            .in_data(sw_in_data), .inv(sw_inv), .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready[g]), .out_data(sw_out_data[g]), .busy(sw_busy[g])
        );
    end

    typedef struct {
        logic [127:0] data;
        logic         iv;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] exp_q[$];
    logic [7:0]   ref_fwd[256];
    logic [7:0]   ref_inv[256];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic build_tables();
        logic [7:0] ex[255];
        int         lg[256];
        logic [7:0] p, q, b;
        logic [7:0] c;
        p = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        for (int x = 0; x < 256; x++) begin
            q = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int i = 0; i < 8; i++)
                b[i] = q[i] ^ q[(i+4)%8] ^ q[(i+5)%8] ^ q[(i+6)%8] ^ q[(i+7)%8] ^ c[i];
            ref_fwd[x] = b;
            ref_inv[b] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = iv ? ref_inv[d[127-8*i -: 8]] : ref_fwd[d[127-8*i -: 8]];
        return r;
    endfunction

    task automatic offer(input logic [127:0] d, input logic iv);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        inv      = iv;
        @(negedge clk);
        in_valid = 1'b0;
        inv      = ~iv;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_out(input string name);
        check({name, "_data"}, out_data, exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_txn(input logic [127:0] d, input logic iv, input logic [127:0] exp);
        int n;
        exp_q.push_back(exp);
        offer(d, iv);
        wait_out(n);
        check("latency", n, NGRP);
        check("busy_in_done", busy, 1);
        finish_out("txn");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic         seen;
        logic [127:0] d, hold, vw;

        build_tables();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; inv = 1'b0; out_ready = 1'b0;
        sw_in_data = '0; sw_inv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_in_valid[k]  = 1'b0;
            sw_out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_out_data", out_data, 0);

        vecs.push_back('{data: 128'h0,          iv: 1'b0, exp: {16{8'h63}}});
        vecs.push_back('{data: FIPS_IN,         iv: 1'b0, exp: FIPS_OUT});
        vecs.push_back('{data: FIPS_OUT,        iv: 1'b1, exp: FIPS_IN});
        vecs.push_back('{data: 128'h0,          iv: 1'b1, exp: {16{8'h52}}});
        vecs.push_back('{data: {16{8'h63}},     iv: 1'b1, exp: 128'h0});
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            vecs.push_back('{data: d, iv: 1'(i % 2), exp: model(d, 1'(i % 2))});
        end
        foreach (vecs[i]) run_txn(vecs[i].data, vecs[i].iv, vecs[i].exp);

        // Backpressure: result held for 10 cycles while a new offer waits.
        d  = {$urandom, $urandom, $urandom, $urandom};
        vw = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(model(d, 1'b0));
        offer(d, 1'b0);
        wait_out(n);
        check("bp_latency", n, NGRP);
        hold = out_data;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid = 1'b1;
                in_data  = vw;
                inv      = 1'b1;
            end
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, hold);
            check("stall_in_ready", in_ready, 0);
        end
        check("stall_result", hold, exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        exp_q.push_back(model(vw, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        inv      = 1'b0;
        check("bp_pending_accepted", busy, 1);
        wait_out(n);
        check("bp_pending_latency", n, NGRP);
        finish_out("bp_pending");

        // Abort: reset lands two edges after the accept.
        offer(FIPS_IN, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", in_ready, 0);
        check("abort_rst_out_valid", out_valid, 0);
        check("abort_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_data", out_data, 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 0);
        run_txn(128'h00112233445566778899aabbccddeeff, 1'b0,
                model(128'h00112233445566778899aabbccddeeff, 1'b0));

        // Lane-count sweep: same vector, latency 16/L.
        for (int k = 0; k < 4; k++) begin
            int lat_exp;
            lat_exp = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 2 : 1;
            sw_in_data = FIPS_IN;
            sw_inv     = 1'b0;
            check("sweep_in_ready", sw_in_ready[k], 1);
            exp_q.push_back(FIPS_OUT);
            sw_in_valid[k] = 1'b1;
            @(negedge clk);
            sw_in_valid[k] = 1'b0;
            sw_inv         = 1'b1;
            n = 0;
            while (!sw_out_valid[k] && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("sweep_latency", n, lat_exp);
            check("sweep_data", sw_out_data[k], exp_q.pop_front());
            sw_out_ready[k] = 1'b1;
            @(negedge clk);
            sw_out_ready[k] = 1'b0;
            check("sweep_valid_drop", sw_out_valid[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
